// File: rtl/mips_loader_pkg.sv
// rtl/mips_loader_pkg.sv - shared state type and word geometry for the imem loader
package mips_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CHK,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - big-endian byte-to-word assembler shared by header, data and checksum
module byte_assembler
    import mips_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    // Only the three earlier bytes are stored; the fourth is taken straight from the input.
    logic [WORD_W-9:0]     shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[WORD_W-17:0], byte_in};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    assign word       = {shift_q, byte_in};
    assign word_valid = byte_valid && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a byte-streamed image into imem; LOADER_CHECKSUM_EN adds a trailing checksum
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam logic [WORD_W:0] DEPTH = (WORD_W + 1)'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t POST_LOAD = CHK;
`else
    localparam state_t POST_LOAD = RUN;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   sum_q, sum_d;
`endif

    logic              accept;
    logic              reload_hit;
    logic [WORD_W-1:0] asm_word;
    logic              asm_valid;

    assign in_ready   = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
    assign accept     = in_valid && in_ready;
    assign reload_hit = reload && ((state_q == RUN) || (state_q == ERR));

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (reload_hit),
        .byte_in    (in_data),
        .byte_valid (accept),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        // Status trails the state by one cycle, except that reload drops it at once.
        cpu_rst_d    = (state_q != RUN) || reload_hit;
        done_d       = (state_q == RUN) && !reload_hit;
        error_d      = (state_q == ERR) && !reload_hit;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        if (reload_hit) begin
            state_d = HDR;
            addr_d  = '0;
            rem_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else if (asm_valid) begin
            case (state_q)
                HDR: begin
                    if (asm_word == '0) begin
                        state_d = POST_LOAD;
                    end else if ({1'b0, asm_word} > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = LOAD;
                        addr_d  = '0;
                        rem_d   = asm_word[ADDR_W:0];
                    end
                end
                LOAD: begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_q;
                    imem_wdata_d = asm_word;
                    addr_d       = addr_q + 1'b1;
                    rem_d        = rem_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = sum_q + asm_word;
`endif
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d = POST_LOAD;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: state_d = (asm_word == sum_q) ? RUN : ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HDR;
            addr_q       <= '0;
            rem_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
